// File: rtl/pixel_queue.sv
// pixel_queue: FIFO between a pixel renderer and a VGA adapter write port.
// Off-screen pixels are dropped and counted; on-screen pixels pass through a
// DEPTH-entry circular buffer into a single output register that drives the
// adapter. When the buffer is empty, an accepted pixel goes straight into a
// free output register, so it is presented the cycle after it was accepted.
module pixel_queue #(
  parameter int DEPTH = 16,
  parameter int X_MAX = 160,
  parameter int Y_MAX = 120
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_x,
  input  logic [6:0]  in_y,
  input  logic [11:0] in_color,
  input  logic        flush,
  output logic [7:0]  VGA_X,
  output logic [6:0]  VGA_Y,
  output logic [11:0] VGA_COLOR,
  output logic        plot,
  input  logic        out_ready,
  output logic        empty,
  output logic [6:0]  count,
  output logic [7:0]  clip_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [6:0] DEPTH_C = 7'(DEPTH);
  localparam logic [7:0] XMAX_C  = 8'(X_MAX);
  localparam logic [6:0] YMAX_C  = 7'(Y_MAX);

  typedef struct packed {
    logic [7:0]  x;
    logic [6:0]  y;
    logic [11:0] color;
  } pixel_t;

  pixel_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [6:0]      count_q, count_d;
  logic [7:0]      clip_q, clip_d;
  logic            plot_q, plot_d;
  pixel_t          out_q, out_d;

  pixel_t          in_pix;
  logic            fifo_empty;
  logic            accept;
  logic            on_screen;
  logic            out_free;
  logic            load_fifo;
  logic            load_direct;
  logic            write;

  assign in_pix     = '{x: in_x, y: in_y, color: in_color};
  assign fifo_empty = (count_q == 7'd0);
  assign in_ready   = (count_q < DEPTH_C) && !flush;
  assign accept     = in_valid && in_ready;
  assign on_screen  = (in_x < XMAX_C) && (in_y < YMAX_C);
  // Output register can take a new pixel when idle or being popped this cycle.
  assign out_free   = !plot_q || out_ready;
  assign load_fifo  = out_free && !fifo_empty;
  // Bypass into the output register only when nothing older is buffered.
  assign load_direct = out_free && fifo_empty && accept && on_screen;
  assign write      = accept && on_screen && !load_direct;

  // Next-state for pointers, occupancy, clip counter and output register.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    clip_d   = clip_q;
    plot_d   = plot_q;
    out_d    = out_q;
    if (write)     wr_ptr_d = wr_ptr_q + AW'(1);
    if (load_fifo) rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + 7'(write) - 7'(load_fifo);
    if (accept && !on_screen && clip_q != 8'hFF) clip_d = clip_q + 8'd1;
    if (load_fifo) begin
      out_d  = mem[rd_ptr_q];
      plot_d = 1'b1;
    end else if (load_direct) begin
      out_d  = in_pix;
      plot_d = 1'b1;
    end else if (plot_q && out_ready) begin
      plot_d = 1'b0;
    end
    // Flush empties the queue but keeps the clip statistic and last VGA fields.
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      plot_d   = 1'b0;
      out_d    = out_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      clip_q   <= '0;
      plot_q   <= 1'b0;
      out_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      clip_q   <= clip_d;
      plot_q   <= plot_d;
      out_q    <= out_d;
    end
  end

  // Storage write; contents are don't-care until the pointers cover them.
  always_ff @(posedge clock) begin
    if (write && !flush && !reset) mem[wr_ptr_q] <= in_pix;
  end

  assign VGA_X      = out_q.x;
  assign VGA_Y      = out_q.y;
  assign VGA_COLOR  = out_q.color;
  assign plot       = plot_q;
  assign count      = count_q;
  assign clip_count = clip_q;
  assign empty      = fifo_empty && !plot_q;

endmodule

// File: doc/pixel_queue.md
PIXEL_QUEUE -- requirements
Module: pixel_queue

Interface
REQ-001 DEPTH, 16, FIFO entries; power of two, 4..64.
REQ-002 X_MAX, 160, horizontal pixel limit; x >= X_MAX is off-screen.
REQ-003 Y_MAX, 120, vertical pixel limit; y >= Y_MAX is off-screen.
REQ-004 clock  in  1  single clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  renderer offers a pixel this cycle.
REQ-007 in_ready  out  1  queue can accept; transfer when in_valid && in_ready.
REQ-008 in_x  in  8  pixel x from the renderer.
REQ-009 in_y  in  7  pixel y from the renderer.
REQ-010 in_color  in  12  pixel colour, 4-bit R, G and B.
REQ-011 flush  in  1  discard all queued and presented pixels.
REQ-012 VGA_X  out  8  presented pixel x.
REQ-013 VGA_Y  out  7  presented pixel y.
REQ-014 VGA_COLOR  out  12  presented pixel colour.
REQ-015 plot  out  1  presented pixel valid; write to the VGA adapter.
REQ-016 out_ready  in  1  adapter accepts; pop when plot && out_ready.
REQ-017 empty  out  1  no stored pixel and plot low.
REQ-018 count  out  7  stored entries, excluding the output register.
REQ-019 clip_count  out  8  saturating count of dropped off-screen pixels.

Function
REQ-020 Storage: DEPTH x 27-bit circular buffer holding {x,y,color}; read and write pointers wrap modulo DEPTH.
REQ-021 in_ready = (count < DEPTH) && !flush; combinational from registered state only.
REQ-022 Accepted pixel with in_x >= X_MAX or in_y >= Y_MAX: not stored; clip_count += 1, saturating at 255.
REQ-023 Accepted on-screen pixel: written at the write pointer.
REQ-024 Output register (VGA_X/VGA_Y/VGA_COLOR/plot) is loaded from the FIFO head when plot is low or (plot && out_ready), and the FIFO is not empty.
REQ-025 Latency: a pixel accepted in cycle N into an empty queue with plot low shows plot=1 in cycle N+1. No same-cycle bypass.
REQ-026 Output fields hold steady while plot && !out_ready.
REQ-027 After a pop with the FIFO empty, plot drops the next cycle; VGA_* keep their last values.
REQ-028 Simultaneous push and head load: count unchanged; order preserved (strict FIFO).
REQ-029 Full (count == DEPTH): in_ready low; draining one entry re-raises in_ready the next cycle.
REQ-030 Throughput: with out_ready held high and in_valid continuous, one pixel per cycle sustained and count stays at 0.
REQ-031 flush: next cycle, count=0, plot=0, pointers=0. The pixel offered during flush is not accepted. clip_count is retained.
REQ-032 flush and reset take priority over push and pop in the same cycle.
REQ-033 empty = (count == 0) && !plot.

Reset
REQ-034 On reset: count=0, pointers=0, plot=0, VGA_X=0, VGA_Y=0, VGA_COLOR=0, clip_count=0, empty=1. in_ready=1 in the following cycle.
REQ-035 Reset mid-stream discards all queued pixels; no stale pixel is presented afterward.
REQ-036 Storage array contents need no reset.

Verification
REQ-037 Single push (12,34,0xF00), out_ready=1 -> plot=1 exactly one cycle later with VGA_X=12, VGA_Y=34, VGA_COLOR=0xF00; then empty=1.
REQ-038 out_ready=0, push 17 pixels (DEPTH=16) -> 1 in the output register, count=16, in_ready=0; 18th pixel held. Raise out_ready -> all 17 emerge in order; no loss or duplication.
REQ-039 Push (160,0), (0,120) and (159,119) -> clip_count=2; only (159,119) plotted.
REQ-040 300 off-screen pushes -> clip_count=255 and holds.
REQ-041 Queue holding 5 entries, flush pulse with in_valid=1 -> next cycle count=0, plot=0, empty=1; offered pixel never plotted.
REQ-042 Continuous 25-pixel 5x5 block stream with random out_ready -> output sequence matches input order; plot never drops while entries remain and out_ready=0.
